dff_bist_ctrl: RTL and testbench
================================

// Module: dff_bist_ctrl
// PURPOSE
//  Self-test driver/checker for the dff_syn flip-flop. It drives the flop's d/en/reset inputs with an LFSR pattern.
//  It checks q/qb against an internal golden model every cycle and reports pass/fail and an error count.
//  Sits beside each dff_syn instance in the flop test harness. It can also sit on-chip as a BIST wrapper.
// PARAMETERS
//  NUM_VECTORS  64     number of RUN cycles (stimulus vectors) per test, >=1
//  SEED         8'hA5  LFSR seed loaded on start, must be nonzero
//  ERR_W        8      width of error counter (saturating)
//  IDX_W        16     width of vector index, must satisfy 2**IDX_W > NUM_VECTORS
// PORTS
//  clk          in   1      rising-edge clock, shared with DUT
//  reset        in   1      synchronous, active-high
//  start        in   1      one-cycle pulse; begins a test when in IDLE or DONE
//  dut_reset    out  1      drives DUT reset
//  dut_d        out  1      drives DUT d
//  dut_en       out  1      drives DUT en
//  dut_q        in   1      DUT q
//  dut_qb       in   1      DUT qb
//  busy         out  1      high in INIT, RUN, DRAIN
//  done         out  1      high in DONE, held until next start/reset
//  pass         out  1      done && err_count==0
//  err_count    out  ERR_W  number of failing checks, saturates at all-ones
// BEHAVIOUR
//  Reset: state=IDLE; lfsr=SEED; exp_q=0; err_count=0; vec_idx=0; all outputs 0.
//  FSM: IDLE -start-> INIT (1 cyc) -> RUN (NUM_VECTORS cyc) -> DRAIN (1 cyc) -> DONE -start-> INIT.
//  start is ignored in INIT/RUN/DRAIN.
//  On an accepted start: lfsr<=SEED, err_count<=0, vec_idx<=0, exp_q<=0.
//  INIT: dut_reset=1, dut_d=0, dut_en=0; at the edge both the DUT and exp_q go to 0.
//  RUN: dut_d=lfsr[0], dut_en=lfsr[1] (combinational from lfsr reg, gated by state); dut_reset=0.
//   Each edge: lfsr<={lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
//   Each edge: exp_q<=dut_en?dut_d:exp_q.
//   Each edge: vec_idx++. Leave RUN when vec_idx==NUM_VECTORS-1.
//  Outside RUN/INIT: dut_d=dut_en=dut_reset=0.
//  Check: in every RUN and DRAIN cycle, mismatch = (dut_q!=exp_q)|(dut_qb!=~exp_q).
//   That gives NUM_VECTORS+1 checks per test; the first check covers the DUT reset value.
//   On mismatch, at the edge err_count<=err_count+1 unless already all-ones.
//  Latency: start to done = NUM_VECTORS+3 cycles (INIT + RUN + DRAIN + 1 edge into DONE).
//  reset during any state: immediate return to IDLE with reset values; a test in flight is discarded.
//  start and reset in the same cycle: reset wins.
//  Unknown (X/Z) on dut_q/dut_qb counts as a mismatch (case-inequality compare).
// CONFIGURATION
//  DFF_BIST_ERRLOG_EN defined: adds ports first_err_vld (out 1) and first_err_idx (out IDX_W).
//   They latch the check index (0 = post-INIT check, k = after vector k) of the first mismatch.
//   Both clear on reset/accepted start; held through DONE.
//  Undefined: ports and logic absent. All other behaviour is identical.
// STRUCTURE
//  Package dff_bist_pkg: state enum (IDLE, INIT, RUN, DRAIN, DONE), LFSR_W=8, tap mask 8'hB8, default seed.
//  Sub-module bist_lfsr (load, seed, advance, state out) is instantiated once.
//  Compare, counters and FSM stay in dff_bist_ctrl.
// TESTING
//  1. dff_syn golden, NUM_VECTORS=64, start pulse -> busy 66 cyc, done at cycle 67, pass=1, err_count=0.
//  2. q stuck-at-0 fault model -> err_count = number of checks with exp_q=1 (bench model), pass=0.
//  3. qb tied to q -> every check fails -> err_count=65; with ERRLOG_EN, first_err_idx=0.
//  4. NUM_VECTORS=300, ERR_W=8, qb fault -> err_count saturates at 8'hFF, no wrap.
//  5. reset asserted at RUN vector 20 -> next cycle IDLE, all outputs 0.
//     A new start then gives a full 64-vector run with the same lfsr sequence as test 1.
//  6. start pulsed mid-RUN -> ignored (vec_idx and timing unchanged).
//     start in DONE -> restart, err_count cleared at INIT.

Source files
------------

// File: rtl/dff_bist_pkg.sv
// Shared types and constants for the dff_syn self-test controller.
// Holds the FSM state encoding, the 8-bit LFSR definition and its step function.
package dff_bist_pkg;

   localparam int                LFSR_W       = 8;
   localparam logic [LFSR_W-1:0] LFSR_TAPS    = 8'hB8;
   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } bist_state_e;

   // Left shift, feedback is the XOR of bits 7,5,4,3 selected by the tap mask.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
      return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/dff_bist_lfsr.sv
// Stimulus LFSR for the flop self-test: loads a seed, advances one step per enabled cycle.
// Reset returns the register to the seed so the first test after reset matches a restarted one.
module bist_lfsr
   import dff_bist_pkg::*;
(
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              load_i,
   input  logic              advance_i,
   input  logic [LFSR_W-1:0] seed_i,
   output logic [LFSR_W-1:0] state_o
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = seed_i;
      end else if (advance_i) begin
         lfsr_d = lfsr_step(lfsr_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         lfsr_q <= seed_i;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state_o = lfsr_q;

endmodule

// File: rtl/dff_bist_ctrl.sv
// Self-test driver/checker for a dff_syn flop: LFSR stimulus, golden model compare, error count.
// Define DFF_BIST_ERRLOG_EN to add first-error capture ports (first_err_vld_o / first_err_idx_o).
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start after reset
// ST_INIT  | one cycle holding the flop in reset, golden model cleared
// ST_RUN   | NUM_VECTORS stimulus cycles, each also checked
// ST_DRAIN | final check of the last vector's result
// ST_DONE  | results held until the next start or reset
module dff_bist_ctrl
   import dff_bist_pkg::*;
#(
   parameter int                NUM_VECTORS = 64,
   parameter logic [LFSR_W-1:0] SEED        = DEFAULT_SEED,
   parameter int                ERR_W       = 8,
   parameter int                IDX_W       = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   output logic             dut_reset_o,
   output logic             dut_d_o,
   output logic             dut_en_o,
   input  logic             dut_q_i,
   input  logic             dut_qb_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
`ifdef DFF_BIST_ERRLOG_EN
   output logic             first_err_vld_o,
   output logic [IDX_W-1:0] first_err_idx_o,
`endif
   output logic [ERR_W-1:0] err_count_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

   bist_state_e       state_q, state_d;
   logic [IDX_W-1:0]  vec_idx_q, vec_idx_d;
   logic [ERR_W-1:0]  err_count_q, err_count_d;
   logic              exp_q_q, exp_q_d;
   logic [LFSR_W-1:0] lfsr_state;
   logic              start_ok;
   logic              check_en;
   logic              mismatch;

   assign start_ok = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   bist_lfsr u_lfsr (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .load_i    (start_ok),
      .advance_i (state_q == ST_RUN),
      .seed_i    (SEED),
      .state_o   (lfsr_state)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_i) state_d = ST_INIT;
         ST_INIT:  state_d = ST_RUN;
         ST_RUN:   if (vec_idx_q == LAST_IDX) state_d = ST_DRAIN;
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  if (start_i) state_d = ST_INIT;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o      = 1'b0;
      done_o      = 1'b0;
      dut_reset_o = 1'b0;
      dut_d_o     = 1'b0;
      dut_en_o    = 1'b0;
      check_en    = 1'b0;
      case (state_q)
         ST_INIT: begin
            busy_o      = 1'b1;
            dut_reset_o = 1'b1;
         end
         ST_RUN: begin
            busy_o   = 1'b1;
            dut_d_o  = lfsr_state[0];
            dut_en_o = lfsr_state[1];
            check_en = 1'b1;
         end
         ST_DRAIN: begin
            busy_o   = 1'b1;
            check_en = 1'b1;
         end
         ST_DONE: done_o = 1'b1;
         default: ;
      endcase
   end

   // Case inequality so an X or Z from the flop is reported as a failure.
   assign mismatch = (dut_q_i !== exp_q_q) || (dut_qb_i !== ~exp_q_q);

   always_comb begin
      vec_idx_d   = vec_idx_q;
      err_count_d = err_count_q;
      exp_q_d     = exp_q_q;
      if (start_ok) begin
         vec_idx_d   = '0;
         err_count_d = '0;
         exp_q_d     = 1'b0;
      end else begin
         if (state_q == ST_INIT) begin
            exp_q_d = 1'b0;
         end
         if (state_q == ST_RUN) begin
            exp_q_d   = dut_en_o ? dut_d_o : exp_q_q;
            vec_idx_d = vec_idx_q + IDX_W'(1);
         end
         if (check_en && mismatch && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         vec_idx_q   <= '0;
         err_count_q <= '0;
         exp_q_q     <= 1'b0;
      end else begin
         vec_idx_q   <= vec_idx_d;
         err_count_q <= err_count_d;
         exp_q_q     <= exp_q_d;
      end
   end

   assign err_count_o = err_count_q;
   assign pass_o      = done_o && (err_count_q == '0);

`ifdef DFF_BIST_ERRLOG_EN
   // vec_idx_q equals the check index: 0 in the first RUN cycle, NUM_VECTORS in DRAIN.
   logic             first_err_vld_q, first_err_vld_d;
   logic [IDX_W-1:0] first_err_idx_q, first_err_idx_d;

   always_comb begin
      first_err_vld_d = first_err_vld_q;
      first_err_idx_d = first_err_idx_q;
      if (start_ok) begin
         first_err_vld_d = 1'b0;
         first_err_idx_d = '0;
      end else if (check_en && mismatch && !first_err_vld_q) begin
         first_err_vld_d = 1'b1;
         first_err_idx_d = vec_idx_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         first_err_vld_q <= 1'b0;
         first_err_idx_q <= '0;
      end else begin
         first_err_vld_q <= first_err_vld_d;
         first_err_idx_q <= first_err_idx_d;
      end
   end

   assign first_err_vld_o = first_err_vld_q;
   assign first_err_idx_o = first_err_idx_q;
`endif

endmodule

// File: tb/tb_dff_bist_ctrl.sv
// Bench for dff_bist_ctrl: behavioural dff_syn with injectable faults and an arithmetic reference model.
// Build with DFF_BIST_ERRLOG_EN defined to also check the first-error capture ports.
module tb_dff_bist_ctrl;

   localparam int         N    = 64;
   localparam int         NB   = 300;
   localparam logic [7:0] SEED = 8'hA5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, start, start_b;
   int   fault_mode;
   logic noise;

   logic       dut_reset, dut_d, dut_en, q_a, qb_a, busy, done, pass;
   logic [7:0] err_count;
   logic       dut_reset_b, dut_d_b, dut_en_b, busy_b, done_b, pass_b;
   logic [7:0] err_count_b;
   logic       ff_a, ff_b;
`ifdef DFF_BIST_ERRLOG_EN
   logic        first_err_vld, first_err_vld_b;
   logic [15:0] first_err_idx, first_err_idx_b;
`endif

   dff_bist_ctrl #(.NUM_VECTORS(N), .SEED(SEED), .ERR_W(8), .IDX_W(16)) u_dut (
      .clk_i(clk), .reset_i(reset), .start_i(start),
      .dut_reset_o(dut_reset), .dut_d_o(dut_d), .dut_en_o(dut_en),
      .dut_q_i(q_a), .dut_qb_i(qb_a),
      .busy_o(busy), .done_o(done), .pass_o(pass),
`ifdef DFF_BIST_ERRLOG_EN
      .first_err_vld_o(first_err_vld), .first_err_idx_o(first_err_idx),
`endif
      .err_count_o(err_count)
   );

   dff_bist_ctrl #(.NUM_VECTORS(NB), .SEED(SEED), .ERR_W(8), .IDX_W(16)) u_dut_b (
      .clk_i(clk), .reset_i(reset), .start_i(start_b),
      .dut_reset_o(dut_reset_b), .dut_d_o(dut_d_b), .dut_en_o(dut_en_b),
      .dut_q_i(ff_b), .dut_qb_i(ff_b),
      .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
`ifdef DFF_BIST_ERRLOG_EN
      .first_err_vld_o(first_err_vld_b), .first_err_idx_o(first_err_idx_b),
`endif
      .err_count_o(err_count_b)
   );

   // Behavioural dff_syn instances.
   always @(posedge clk) begin
      if (dut_reset) ff_a <= 1'b0;
      else if (dut_en) ff_a <= dut_d;
      if (dut_reset_b) ff_b <= 1'b0;
      else if (dut_en_b) ff_b <= dut_d_b;
   end

   // Fault modes: 0 golden, 1 q stuck-at-0, 2 qb tied to q, 3 random qb corruption.
   always_comb begin
      q_a  = ff_a;
      qb_a = ~ff_a;
      case (fault_mode)
         1: q_a = 1'b0;
         2: qb_a = ff_a;
         3: qb_a = ~ff_a ^ noise;
         default: ;
      endcase
   end

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] s_ref [0:N];
   int         e_ref [0:N];
   int         ones_ref;
   int         first_one;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic run_one(input int mode, input bit mid_start);
      int cyc, nz, first_nz, exp_err, exp_idx;
      fault_mode = mode;
      nz = 0;
      first_nz = -1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("init_err_clr", 32'(err_count), 0);
      check("init_flags", {busy, done, pass}, 3'b100);
      check("init_drive", {dut_reset, dut_d, dut_en}, 3'b100);
      cyc = 0;
      while (busy === 1'b1 && cyc < N + 10) begin
         noise = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (cyc >= 1 && noise) begin
            if (first_nz < 0) first_nz = cyc - 1;
            nz++;
         end
         if (cyc >= 1 && cyc <= N)
            check("run_drive", {dut_reset, dut_d, dut_en}, {1'b0, s_ref[cyc-1][0], s_ref[cyc-1][1]});
         start = (mid_start && cyc == 10) ? 1'b1 : 1'b0;
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      noise = 1'b0;
      case (mode)
         1:       begin exp_err = ones_ref; exp_idx = first_one; end
         2:       begin exp_err = N + 1;    exp_idx = 0;         end
         3:       begin exp_err = nz;       exp_idx = first_nz;  end
         default: begin exp_err = 0;        exp_idx = 0;         end
      endcase
      check("busy_len", cyc, N + 2);
      check("done_flags", {busy, done}, 2'b01);
      check("err_count", 32'(err_count), exp_err);
      check("pass", 32'(pass), (exp_err == 0) ? 1 : 0);
      check("done_drive", {dut_reset, dut_d, dut_en}, 3'b000);
`ifdef DFF_BIST_ERRLOG_EN
      check("first_vld", 32'(first_err_vld), (exp_err != 0) ? 1 : 0);
      if (exp_err != 0) check("first_idx", 32'(first_err_idx), exp_idx);
`endif
   endtask

   initial begin
      int cyc, fb;
      reset = 1'b1;
      start = 1'b0;
      start_b = 1'b0;
      fault_mode = 0;
      noise = 1'b0;

      s_ref[0] = SEED;
      e_ref[0] = 0;
      for (int k = 0; k < N; k++) begin
         fb = ((s_ref[k] >> 7) ^ (s_ref[k] >> 5) ^ (s_ref[k] >> 4) ^ (s_ref[k] >> 3)) & 1;
         s_ref[k+1] = 8'(((s_ref[k] * 2) % 256) + fb);
         e_ref[k+1] = s_ref[k][1] ? int'(s_ref[k][0]) : e_ref[k];
      end
      ones_ref = 0;
      first_one = -1;
      for (int k = 0; k <= N; k++) begin
         ones_ref += e_ref[k];
         if (e_ref[k] == 1 && first_one < 0) first_one = k;
      end

      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      check("reset_wins", {busy, done}, 2'b00);
      start = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check("reset_outs", {busy, done, pass, dut_reset, dut_d, dut_en, err_count}, 0);

      run_one(0, 1'b0);
      run_one(1, 1'b0);
      run_one(2, 1'b0);
      run_one(0, 1'b1);
      repeat (3) run_one(3, 1'b0);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (21) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrun_reset", {busy, done, pass, dut_reset, dut_d, dut_en, err_count}, 0);
`ifdef DFF_BIST_ERRLOG_EN
      check("midrun_reset_log", 32'(first_err_vld), 0);
`endif
      @(negedge clk);
      run_one(1, 1'b0);
      run_one(0, 1'b0);

      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      cyc = 0;
      while (busy_b === 1'b1 && cyc < NB + 10) begin
         cyc++;
         @(negedge clk);
      end
      check("sat_busy_len", cyc, NB + 2);
      check("sat_err", 32'(err_count_b), 32'hFF);
      check("sat_flags", {done_b, pass_b}, 2'b10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
